trng_seq_ctrl: RTL and testbench
================================

Name: trng_seq_ctrl

Overview:
Sequencer for the TRNG entropy datapath behind the 4-register AXI4-Lite slave.
- Gates the ring oscillator and waits a warm-up period.
- Samples the raw entropy bit at a divided rate, runs a repetition-count health test and packs bits into 32-bit words.
- Buffers words in a small show-ahead FIFO that the register file pops on a data-register read.

Parameters:
WARMUP_CYCLES, 256, ACLK cycles oscillator runs before sampling starts (>=1)
SAMPLE_DIV, 8, ACLK cycles per entropy sample (>=2)
FIFO_DEPTH, 4, number of 32-bit words buffered (power of 2, >=2)
REP_LIMIT, 32, consecutive identical raw samples that trip the health test (2..255)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
cfg_enable  in  1  level; run the sequencer
cfg_clear_err  in  1  pulse; leave ERROR state
cfg_flush  in  1  pulse; empty the FIFO
ent_bit  in  1  raw oscillator output, asynchronous to ACLK
osc_en  out  1  oscillator enable
rd_req  in  1  pulse; pop FIFO head
rd_data  out  32  FIFO head word (show-ahead)
rd_valid  out  1  FIFO not empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  words held
busy  out  1  state is WARMUP, COLLECT or FULL_WAIT
err_rep  out  1  health test failure, latched

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, state IDLE, all counters 0.
- ent_bit passes through a 2-flop synchronizer before use.
- IDLE: osc_en=0. When cfg_enable=1, go to WARMUP and set osc_en=1 on the next edge.
- WARMUP: counts WARMUP_CYCLES cycles, then enters COLLECT.
- COLLECT:
  - The sample counter runs 0..SAMPLE_DIV-1; the synced bit is sampled when the count is SAMPLE_DIV-1.
  - Shift: word <= {word[30:0], bit}.
  - After the 32nd accepted bit, the word is pushed if FIFO not full; otherwise go to FULL_WAIT holding the word.
  - The bit counter wraps to 0 after each word.
- FULL_WAIT:
  - Sampling is stalled; osc_en stays 1.
  - The word is pushed on the first cycle the FIFO is not full, then return to COLLECT with the sample counter restarted.
- Health test on every raw sample:
  - The run counter resets to 1 when the sample differs from the previous sample, else increments (saturating).
  - When the counter reaches REP_LIMIT, go to ERROR.
  - ERROR: err_rep=1, osc_en=0, partial word discarded, FIFO retained.
  - ERROR to IDLE only on cfg_clear_err, which also clears err_rep.
- cfg_enable=0 in WARMUP, COLLECT or FULL_WAIT: go to IDLE next edge, osc_en=0 the same edge, partial or held word discarded, FIFO retained. cfg_enable is ignored in ERROR.
- FIFO:
  - rd_data always equals the head word; rd_data=0 when empty.
  - rd_req on empty is ignored.
  - A push and a pop in the same cycle are both taken when the FIFO is non-empty and not full; level is unchanged.
  - When full, a pop in the same cycle does not admit a push; the push occurs the next cycle.
  - cfg_flush empties the FIFO next edge and overrides a same-cycle push or pop. The word being pushed is dropped; the partial word is kept.
- Latency from cfg_enable rising to the first rd_valid: 1 + WARMUP_CYCLES + 32*SAMPLE_DIV + 1 cycles, ±2 for synchronizer alignment.

Optional Feature:
TRNG_VN_DEBIAS_EN
- Defined: von Neumann debias on consecutive raw sample pairs.
  - Pair 01 produces bit 0; pair 10 produces bit 1; pairs 00 and 11 produce nothing.
  - Only produced bits enter the shift register.
  - The health test still sees every raw sample.
  - A pair in progress is discarded on any exit from COLLECT.
- Undefined: every raw sample is shifted in directly.

Test Plan:
Bench parameters: WARMUP_CYCLES=16, SAMPLE_DIV=4, FIFO_DEPTH=4, REP_LIMIT=8.
- Alternating ent_bit 1,0,1,0 aligned to the sample strobe, cfg_enable=1 -> osc_en=1 one cycle later, busy=1. First word rd_data=0xAAAAAAAA with rd_valid=1, fifo_level=1. rd_req -> fifo_level=0, rd_data=0.
- ent_bit stuck at 1 -> err_rep=1 and osc_en=0 after the 8th sample; FIFO level unchanged; further samples ignored. cfg_clear_err -> IDLE, err_rep=0, WARMUP restarts if cfg_enable=1.
- Alternating stimulus with no reads for 5 words -> fifo_level=4, state FULL_WAIT, osc_en=1. One rd_req -> level 3, then 4 the next cycle from the held word.
- cfg_enable dropped after 10 bits of word 2 -> IDLE, osc_en=0 next edge, fifo_level=1 retained. Re-enable -> full WARMUP of 16 cycles, then a fresh 32-bit word.
- ARESETN low mid-COLLECT with 2 words buffered -> all outputs 0 immediately, fifo_level=0. After release, IDLE until cfg_enable is seen.
- With TRNG_VN_DEBIAS_EN, raw pattern 0,1 repeated -> rd_data=0x00000000 after 64 samples. Pattern 1,1,1,0 repeated -> 0xFFFFFFFF after 128 samples, no err_rep.

Source files
------------

// File: rtl/trng_seq_ctrl.sv
// trng_seq_ctrl -- entropy sequencer for the TRNG behind the AXI4-Lite register file.
//
// Gates the ring oscillator, waits a warm-up period, samples the synchronised raw
// entropy bit every SAMPLE_DIV cycles, runs a repetition-count health test on each
// raw sample and packs accepted bits MSB-first into 32-bit words. Finished words
// go into a FIFO_DEPTH-word show-ahead FIFO that the register file pops.
//
// Optional build macro: TRNG_VN_DEBIAS_EN
//   When defined, raw samples are von Neumann debiased in pairs (01 -> 0, 10 -> 1,
//   00/11 -> nothing) before they reach the shift register.
//
// Ports:
//   ACLK, ARESETN   clock, asynchronous active-low reset (release assumed to be
//                   synchronised to ACLK upstream)
//   cfg_enable      level, run the sequencer (ignored in ERROR)
//   cfg_clear_err   pulse, leave ERROR and clear err_rep
//   cfg_flush       pulse, empty the FIFO (wins over same-cycle push/pop)
//   ent_bit         raw oscillator output, asynchronous
//   osc_en          oscillator enable
//   rd_req          pulse, pop FIFO head
//   rd_data         FIFO head word, 0 when empty
//   rd_valid        FIFO not empty
//   fifo_level      words held
//   busy            WARMUP, COLLECT or FULL_WAIT
//   err_rep         health test failure, held until cfg_clear_err
module trng_seq_ctrl #(
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cfg_enable,
  input  logic                          cfg_clear_err,
  input  logic                          cfg_flush,
  input  logic                          ent_bit,
  output logic                          osc_en,
  input  logic                          rd_req,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          err_rep
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int SW = $clog2(SAMPLE_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_COLLECT, S_FULL_WAIT, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic [WW-1:0]  wcnt_q, wcnt_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic [4:0]     bcnt_q, bcnt_d;
  logic [31:0]    word_q, word_d;
  logic           prev_q, prev_d;
  logic [7:0]     run_q, run_d;
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [LW-1:0]  cnt_q;
  logic [31:0]    mem_q [FIFO_DEPTH];

  logic           ent_s, strobe, rep_trip, bit_ok, bit_val, push;
  logic [7:0]     run_nxt;
  logic [31:0]    word_shift, push_data;
  logic           full, empty, wr_en, pop_en;

  assign ent_s  = sync_q[1];
  assign full   = (cnt_q == LW'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign strobe = (state_q == S_COLLECT) && cfg_enable && (scnt_q == SW'(SAMPLE_DIV - 1));

  // run_q == 0 means no previous sample since IDLE, so the first sample starts a run of 1.
  assign run_nxt  = (run_q == 8'd0 || ent_s != prev_q) ? 8'd1 :
                    (run_q == 8'hFF) ? run_q : run_q + 8'd1;
  assign rep_trip = strobe && (run_nxt == 8'(REP_LIMIT));

`ifdef TRNG_VN_DEBIAS_EN
  logic vn_have_q, vn_have_d, vn_first_q, vn_first_d;
  // The first sample of a pair is emitted only if the second one differs from it.
  assign bit_ok  = strobe && vn_have_q && (vn_first_q != ent_s);
  assign bit_val = vn_first_q;
`else
  assign bit_ok  = strobe;
  assign bit_val = ent_s;
`endif

  assign word_shift = {word_q[30:0], bit_val};

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    prev_d    = prev_q;
    run_d     = run_q;
    push      = 1'b0;
    push_data = word_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable) state_d = S_WARMUP;
      end
      S_WARMUP: begin
        if (!cfg_enable)                          state_d = S_IDLE;
        else if (wcnt_q == WW'(WARMUP_CYCLES - 1)) state_d = S_COLLECT;
        else                                       wcnt_d  = wcnt_q + WW'(1);
      end
      S_COLLECT: begin
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else begin
          scnt_d = strobe ? '0 : scnt_q + SW'(1);
          if (strobe) begin
            prev_d = ent_s;
            run_d  = run_nxt;
          end
          // A health failure wins over a word completing on the same sample.
          if (rep_trip) begin
            state_d = S_ERROR;
          end else if (bit_ok) begin
            word_d = word_shift;
            bcnt_d = bcnt_q + 5'd1;
            if (bcnt_q == 5'd31) begin
              if (!full) begin
                push      = 1'b1;
                push_data = word_shift;
              end else begin
                state_d = S_FULL_WAIT;
              end
            end
          end
        end
      end
      S_FULL_WAIT: begin
        // word_q holds the completed word while sampling is stalled.
        if (!cfg_enable) begin
          state_d = S_IDLE;
        end else if (!full) begin
          push    = 1'b1;
          state_d = S_COLLECT;
          scnt_d  = '0;
        end
      end
      S_ERROR: begin
        if (cfg_clear_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Leaving the active states discards any partial or held word.
    if (state_d == S_IDLE || state_d == S_ERROR) begin
      wcnt_d = '0;
      scnt_d = '0;
      bcnt_d = '0;
      word_d = '0;
    end
    if (state_d == S_IDLE) run_d = '0;
  end

`ifdef TRNG_VN_DEBIAS_EN
  always_comb begin
    vn_have_d  = vn_have_q;
    vn_first_d = vn_first_q;
    if (state_d != S_COLLECT) begin
      vn_have_d = 1'b0;
    end else if (strobe) begin
      vn_have_d = !vn_have_q;
      if (!vn_have_q) vn_first_d = ent_s;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vn_have_q  <= 1'b0;
      vn_first_q <= 1'b0;
    end else begin
      vn_have_q  <= vn_have_d;
      vn_first_q <= vn_first_d;
    end
  end
`endif

  // Flush overrides both sides; a push is only offered when the FIFO is not full.
  assign wr_en  = push && !full && !cfg_flush;
  assign pop_en = rd_req && !empty && !cfg_flush;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      sync_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      prev_q  <= 1'b0;
      run_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], ent_bit};
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      if (cfg_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (wr_en)  wptr_q <= wptr_q + AW'(1);
        if (pop_en) rptr_q <= rptr_q + AW'(1);
        if (wr_en && !pop_en)      cnt_q <= cnt_q + LW'(1);
        else if (!wr_en && pop_en) cnt_q <= cnt_q - LW'(1);
      end
    end
  end

  // Word storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_q[wptr_q] <= push_data;
  end

  assign rd_data    = empty ? 32'd0 : mem_q[rptr_q];
  assign rd_valid   = !empty;
  assign fifo_level = cnt_q;
  assign busy       = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_FULL_WAIT);
  assign osc_en     = busy;
  assign err_rep    = (state_q == S_ERROR);

endmodule

// File: tb/tb_trng_seq_ctrl.sv
// Bench for trng_seq_ctrl: directed scenarios plus a randomized phase, all checked
// every cycle against a phase/queue model of the sequencer kept in this file.
module tb_trng_seq_ctrl;
  localparam int W  = 16;
  localparam int SD = 4;
  localparam int D  = 4;
  localparam int R  = 8;
`ifdef TRNG_VN_DEBIAS_EN
  localparam int SPW = 64;   // alternating raw samples needed per word
`else
  localparam int SPW = 32;
`endif
  localparam int LAT = 1 + W + SPW * SD;  // ticks from enable to first word

  localparam int P_IDLE = 0, P_WARM = 1, P_COL = 2, P_FULL = 3, P_ERR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0, cfg_clear_err = 1'b0, cfg_flush = 1'b0;
  logic        ent_bit = 1'b0, rd_req = 1'b0;
  logic        osc_en, rd_valid, busy, err_rep;
  logic [31:0] rd_data;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  trng_seq_ctrl #(.WARMUP_CYCLES(W), .SAMPLE_DIV(SD), .FIFO_DEPTH(D), .REP_LIMIT(R)) dut (
    .ACLK(clk), .ARESETN(rst_n), .cfg_enable(cfg_enable), .cfg_clear_err(cfg_clear_err),
    .cfg_flush(cfg_flush), .ent_bit(ent_bit), .osc_en(osc_en), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level), .busy(busy),
    .err_rep(err_rep)
  );

  int tests_run = 0, tests_failed = 0;
  int edge_n = 0;
  int ent_mode = 3;          // 0 random, 1 anchored pattern, 2 stuck at 1, 3 alternating by cycle
  int anchor = 0;
  int pat_len = 2;
  logic pat [0:3];

  // Model state
  int          m_phase, m_ph, m_n, m_run;
  logic [31:0] m_acc, m_held;
  logic        m_prev, m_s1, m_s2, m_vh, m_vf;
  logic [31:0] m_fifo [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_ph = 0; m_n = 0; m_run = 0;
    m_acc = '0; m_held = '0; m_prev = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    m_vh = 1'b0; m_vf = 1'b0;
    m_fifo.delete();
  endtask

  task automatic go_idle();
    m_phase = P_IDLE; m_ph = 0; m_n = 0; m_acc = '0; m_vh = 1'b0;
  endtask

  // One clock edge of the model, using the input values that were present before the edge.
  task automatic model_step();
    logic s, b;
    bit full, push, pop, b_ok;
    logic [31:0] pw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_s2; m_s2 = m_s1; m_s1 = ent_bit;
    full = (m_fifo.size() == D);
    pop  = rd_req && (m_fifo.size() != 0);
    push = 0; pw = '0; b_ok = 0; b = 1'b0;
    case (m_phase)
      P_IDLE: begin
        m_run = 0;
        if (cfg_enable) begin m_phase = P_WARM; m_ph = 0; end
      end
      P_WARM: begin
        if (!cfg_enable) go_idle();
        else begin
          m_ph++;
          if (m_ph == W) begin m_phase = P_COL; m_ph = 0; end
        end
      end
      P_COL: begin
        if (!cfg_enable) go_idle();
        else begin
          m_ph++;
          if (m_ph % SD == 0) begin
            m_run = (m_run == 0 || s !== m_prev) ? 1 : m_run + 1;
            m_prev = s;
            if (m_run == R) begin
              m_phase = P_ERR; m_n = 0; m_acc = '0; m_vh = 1'b0;
            end else begin
`ifdef TRNG_VN_DEBIAS_EN
              if (m_vh) begin
                m_vh = 1'b0;
                if (m_vf !== s) begin b_ok = 1; b = m_vf; end
              end else begin
                m_vh = 1'b1; m_vf = s;
              end
`else
              b_ok = 1; b = s;
`endif
              if (b_ok) begin
                m_acc = (m_acc << 1) | {31'd0, b};
                m_n++;
                if (m_n == 32) begin
                  m_n = 0;
                  if (!full) begin push = 1; pw = m_acc; end
                  else begin m_phase = P_FULL; m_held = m_acc; m_vh = 1'b0; end
                end
              end
            end
          end
        end
      end
      P_FULL: begin
        if (!cfg_enable) go_idle();
        else if (!full) begin push = 1; pw = m_held; m_phase = P_COL; m_ph = 0; end
      end
      default: begin
        if (cfg_clear_err) m_phase = P_IDLE;
      end
    endcase
    if (cfg_flush) m_fifo.delete();
    else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(pw);
    end
  endtask

  task automatic compare_all();
    logic eb;
    eb = (m_phase == P_WARM || m_phase == P_COL || m_phase == P_FULL);
    chk("osc_en", 32'(osc_en), 32'(eb));
    chk("busy", 32'(busy), 32'(eb));
    chk("err_rep", 32'(err_rep), 32'(m_phase == P_ERR));
    chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    chk("rd_valid", 32'(rd_valid), 32'(m_fifo.size() != 0));
    chk("rd_data", rd_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
  endtask

  task automatic drive_ent();
    int u, idx;
    u = edge_n + 1;
    case (ent_mode)
      0: ent_bit = 1'($urandom_range(0, 1));
      1: begin
        idx = (u + 1 - anchor >= 0) ? (u + 1 - anchor) / SD : 0;
        ent_bit = pat[idx % pat_len];
      end
      2: ent_bit = 1'b1;
      default: ent_bit = ((u / SD) % 2) == 1;
    endcase
  endtask

  task automatic tick();
    drive_ent();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_level(input int target, input int bound, input string nm, output int n);
    n = 0;
    while (int'(fifo_level) != target && n < bound) begin tick(); n++; end
    chk(nm, 32'(fifo_level), 32'(target));
  endtask

  task automatic wait_err(input int bound, output int n);
    n = 0;
    while (!err_rep && n < bound) begin tick(); n++; end
    chk("err_wait", 32'(err_rep), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_osc_en", 32'(osc_en), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_err", 32'(err_rep), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    bit in_rng;
    // Reset
    do_reset();
    cfg_enable = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_osc_en", 32'(osc_en), 32'd0);

    // Alternating 1,0 aligned to the sample strobe
    ent_mode = 1; pat[0] = 1'b1; pat[1] = 1'b0; pat_len = 2;
    anchor = edge_n + 1 + W;
    cfg_enable = 1'b1;
    tick();
    chk("en_osc_en", 32'(osc_en), 32'd1);
    chk("en_busy", 32'(busy), 32'd1);
    wait_level(1, 700, "first_word", n);
    in_rng = (n + 1 >= LAT - 1) && (n + 1 <= LAT + 3);
    chk("first_latency_ok", 32'(in_rng), 32'd1);
`ifdef TRNG_VN_DEBIAS_EN
    chk("first_word_data", rd_data, 32'hFFFFFFFF);
`else
    chk("first_word_data", rd_data, 32'hAAAAAAAA);
`endif
    chk("first_word_valid", 32'(rd_valid), 32'd1);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("pop_level", 32'(fifo_level), 32'd0);
    chk("pop_data", rd_data, 32'd0);
    cfg_enable = 1'b0; tick();

    // Stuck-at-1 health failure with one word buffered
    ent_mode = 3; cfg_enable = 1'b1;
    wait_level(1, 700, "pre_err_word", n);
    ent_mode = 2;
    wait_err(120, n);
    chk("err_osc_en", 32'(osc_en), 32'd0);
    chk("err_level", 32'(fifo_level), 32'd1);
    repeat (60) tick();
    chk("err_hold", 32'(err_rep), 32'd1);
    chk("err_hold_level", 32'(fifo_level), 32'd1);
    ent_mode = 3;
    cfg_clear_err = 1'b1; tick(); cfg_clear_err = 1'b0;
    chk("clr_err", 32'(err_rep), 32'd0);
    chk("clr_osc_en", 32'(osc_en), 32'd0);
    tick();
    chk("rewarm_osc_en", 32'(osc_en), 32'd1);

    // Fill the FIFO and stall in FULL_WAIT
    cfg_flush = 1'b1; tick(); cfg_flush = 1'b0;
    wait_level(4, 1500, "fill", n);
    repeat (SPW * SD + 10) tick();
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_osc_en", 32'(osc_en), 32'd1);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("full_pop_level", 32'(fifo_level), 32'd3);
    tick();
    chk("held_push_level", 32'(fifo_level), 32'd4);

    // Disable mid-word, FIFO retained, re-enable restarts warm-up
    cfg_flush = 1'b1; tick(); cfg_flush = 1'b0;
    wait_level(1, 700, "dis_word1", n);
    repeat (10 * SD) tick();
    cfg_enable = 1'b0; tick();
    chk("dis_osc_en", 32'(osc_en), 32'd0);
    chk("dis_level", 32'(fifo_level), 32'd1);
    cfg_enable = 1'b1;
    wait_level(2, 700, "reen_word", n);
    in_rng = (n >= LAT - 1) && (n <= LAT + 3);
    chk("reen_latency_ok", 32'(in_rng), 32'd1);

    // Asynchronous reset mid-COLLECT with two words buffered
    repeat (20) tick();
    #2;
    do_reset();
    cfg_enable = 1'b0;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("post_rst_idle", 32'(osc_en), 32'd0);
    cfg_enable = 1'b1; tick();
    chk("post_rst_en", 32'(osc_en), 32'd1);

    // Randomized phase
    ent_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      rd_req        = ($urandom_range(0, 3) == 0);
      cfg_flush     = ($urandom_range(0, 199) == 0);
      cfg_clear_err = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) cfg_enable = !cfg_enable;
      tick();
    end
    rd_req = 1'b0; cfg_flush = 1'b0; cfg_clear_err = 1'b0; cfg_enable = 1'b0;
    tick();

`ifdef TRNG_VN_DEBIAS_EN
    // Debias: 0,1 pairs give zeros; 1,1,1,0 gives one 1 per four samples
    do_reset();
    rst_n = 1'b1;
    tick();
    ent_mode = 1; pat[0] = 1'b0; pat[1] = 1'b1; pat_len = 2;
    anchor = edge_n + 1 + W;
    cfg_enable = 1'b1;
    wait_level(1, 700, "vn01_word", n);
    chk("vn01_data", rd_data, 32'h00000000);
    in_rng = (n >= 1 + W + 64 * SD - 1) && (n <= 1 + W + 64 * SD + 3);
    chk("vn01_latency_ok", 32'(in_rng), 32'd1);
    cfg_enable = 1'b0; cfg_flush = 1'b1; tick(); cfg_flush = 1'b0;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0; pat_len = 4;
    anchor = edge_n + 1 + W;
    cfg_enable = 1'b1;
    wait_level(1, 1000, "vn1110_word", n);
    chk("vn1110_data", rd_data, 32'hFFFFFFFF);
    chk("vn1110_err", 32'(err_rep), 32'd0);
    in_rng = (n >= 1 + W + 128 * SD - 1) && (n <= 1 + W + 128 * SD + 3);
    chk("vn1110_latency_ok", 32'(in_rng), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
